uart_tx_serializer: RTL and testbench

Asynchronous-serial transmitter that converts a parallel byte into an 8N1/8E1/8O1-style frame on a single line. It is the transmit-side counterpart of the lab's serial receiver and storage elements. It sits between a parallel data producer, which uses a valid/ready handshake, and the tx pin. A one-hot-free binary FSM sequences the frame, and a baud counter times each bit.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_serializer_baud.sv | 34 +++
 rtl/uart_tx_serializer.sv | 122 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the serial transmit and receive datapaths.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package uart_pkg;

  // Frame sequencer states, binary encoded
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Default frame geometry
  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Even parity (XOR reduction) of up to 16 payload bits; callers zero-extend
  function automatic logic parity16(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: tick is combinational from the count, first tick CLKS_PER_BIT cycles after clr drops.
// Backpressure: none; clr holds the count at zero and suppresses tick.
module baud_tick_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Terminal count marks the final cycle of the current bit
  assign tick = !clr && (cnt == CNT_LAST);

  // Free-run within a bit, restart at zero on every bit boundary or clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Serialises one parallel word into a start/data/[parity]/stop frame on tx_out, LSB first.
// Latency: start bit drives from the accept edge; (2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT cycles until ready again.
// Backpressure: tx_ready low for the whole frame; tx_valid/tx_data ignored until tx_ready returns.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic                  parity_bit;
  logic                  accept;
  logic                  baud_clr;
  logic                  baud_tick;

  assign accept   = tx_valid && tx_ready;
  // Bit timer only runs while a frame is on the line
  assign baud_clr = (state == ST_IDLE);

  baud_tick_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  // Frame sequencer: every output is a register so the line never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_out     <= LINE_IDLE;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_out <= LINE_IDLE;
          if (accept) begin
            state      <= ST_START;
            tx_out     <= START_BIT;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            shreg      <= tx_data;
            bit_idx    <= '0;
            // Parity is fixed at accept so later tx_data changes cannot leak in
            parity_bit <= parity16(16'(tx_data)) ^ ODD_BIT;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state  <= ST_DATA;
            tx_out <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state  <= ST_PARITY;
                tx_out <= parity_bit;
              end else begin
                state  <= ST_STOP;
                tx_out <= LINE_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            state  <= ST_STOP;
            tx_out <= LINE_IDLE;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            state    <= ST_IDLE;
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_out   <= LINE_IDLE;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: three transmitters (no parity, even parity, odd parity) at 4 clocks per bit.
// Latency: each frame checked cycle by cycle against hand-derived line levels.
// Backpressure: tx_ready/tx_busy/tx_done checked at every bit boundary and at frame end.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dat [3];
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] txo;
  logic [2:0] bsy;
  logic [2:0] dn;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst(rst), .tx_data(dat[2]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx_out(txo[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Called just after the accept edge; walks the frame and returns just after the tx_done edge.
  // At bit mid_bit tx_data is overwritten with mid_d; during the stop bit it becomes next_d.
  task automatic run_frame(input int k, input logic [7:0] b, input bit has_par, input logic pbit,
                           input string tag, input int mid_bit, input logic [7:0] mid_d,
                           input logic [7:0] next_d);
    int   nb;
    logic exp;
    nb = has_par ? 11 : 10;
    for (int i = 0; i < nb; i++) begin
      if (i == 0)                  exp = 1'b0;
      else if (i <= 8)             exp = b[i-1];
      else if (has_par && i == 9)  exp = pbit;
      else                         exp = 1'b1;
      if (i == mid_bit)  dat[k] = mid_d;
      if (i == nb - 1)   dat[k] = next_d;
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s_bit%0d_c%0d", tag, i, c), txo[k], exp);
        if (c == 0) begin
          chk($sformatf("%s_bit%0d_ready", tag, i), rdy[k], 1'b0);
          chk($sformatf("%s_bit%0d_busy", tag, i), bsy[k], 1'b1);
          chk($sformatf("%s_bit%0d_done", tag, i), dn[k], 1'b0);
        end
        step();
      end
    end
    chk({tag, "_end_done"}, dn[k], 1'b1);
    chk({tag, "_end_ready"}, rdy[k], 1'b1);
    chk({tag, "_end_busy"}, bsy[k], 1'b0);
    chk({tag, "_end_line"}, txo[k], 1'b1);
  endtask

  // Single-word send on instance k with a one-cycle valid pulse, then confirm done drops
  task automatic send_one(input int k, input logic [7:0] b, input bit has_par, input logic pbit,
                          input string tag);
    dat[k] = b;
    vld[k] = 1'b1;
    step();
    vld[k] = 1'b0;
    run_frame(k, b, has_par, pbit, tag, -1, b, b);
    step();
    chk({tag, "_done_once"}, dn[k], 1'b0);
    chk({tag, "_idle_ready"}, rdy[k], 1'b1);
  endtask

  initial begin
    vld = 3'b000;
    for (int k = 0; k < 3; k++) dat[k] = 8'h00;

    // Reset held for three edges
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_line%0d", k), txo[k], 1'b1);
      chk($sformatf("rst_ready%0d", k), rdy[k], 1'b1);
      chk($sformatf("rst_busy%0d", k), bsy[k], 1'b0);
      chk($sformatf("rst_done%0d", k), dn[k], 1'b0);
    end
    rst = 1'b0;

    // No valid: line stays idle
    repeat (3) begin
      step();
      chk("novalid_line", txo[0], 1'b1);
      chk("novalid_ready", rdy[0], 1'b1);
    end

    // Single frame, 0xA5
    send_one(0, 8'hA5, 1'b0, 1'b0, "a5");

    // Parity frames (44 cycles each)
    send_one(1, 8'hA5, 1'b1, 1'b0, "even_a5");
    send_one(2, 8'h07, 1'b1, 1'b0, "odd_07");
    send_one(1, 8'h07, 1'b1, 1'b1, "even_07");

    // Back-to-back with valid held; tx_data disturbed mid-frame
    dat[0] = 8'h3C;
    vld[0] = 1'b1;
    step();
    run_frame(0, 8'h3C, 1'b0, 1'b0, "b2b_3c", 4, 8'hFF, 8'hC3);
    step();
    vld[0] = 1'b0;
    chk("b2b_gap_start", txo[0], 1'b0);
    chk("b2b_gap_done", dn[0], 1'b0);
    run_frame(0, 8'hC3, 1'b0, 1'b0, "b2b_c3", -1, 8'hC3, 8'hC3);
    step();
    chk("b2b_done_once", dn[0], 1'b0);

    // Reset during data bit 3 of 0x00
    dat[0] = 8'h00;
    vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    repeat (17) step();
    chk("mid_before_rst_line", txo[0], 1'b0);
    chk("mid_before_rst_busy", bsy[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_line", txo[0], 1'b1);
    chk("mid_rst_ready", rdy[0], 1'b1);
    chk("mid_rst_busy", bsy[0], 1'b0);
    chk("mid_rst_done", dn[0], 1'b0);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_line", txo[0], 1'b1);
    chk("post_rst_ready", rdy[0], 1'b1);
    send_one(0, 8'h81, 1'b0, 1'b0, "post_81");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
